// File: rtl/alarm_sequencer_if.sv
// Signal bundle between the alarm sequencer, the timekeeping counters,
// the external melody ROM and the buzzer pin.
interface alarm_sequencer_if #(
  parameter int PERIOD_W = 20,
  parameter int ADDR_W   = 5
);
  logic                en;
  logic [5:0]          cur_hour;
  logic [5:0]          cur_min;
  logic [5:0]          al_hour;
  logic [5:0]          al_min;
  logic                snooze;
  logic                stop;
  logic [ADDR_W-1:0]   note_addr;
  logic [PERIOD_W-1:0] note_period;
  logic                speak;
  logic                busy;

  modport master (
    output en, cur_hour, cur_min, al_hour, al_min, snooze, stop, note_period,
    input  note_addr, speak, busy
  );

  modport slave (
    input  en, cur_hour, cur_min, al_hour, al_min, snooze, stop, note_period,
    output note_addr, speak, busy
  );
endinterface

// File: rtl/alarm_sequencer.sv
// Alarm melody player: triggers on the rising edge of a time match and walks an
// external note table, producing a square wave with repeat, snooze and stop.
module alarm_sequencer #(
  parameter int PERIOD_W     = 20,
  parameter int LEN          = 19,
  parameter int ADDR_W       = 5,
  parameter int TICK_DIV     = 25_000_000,
  parameter int REPEATS      = 3,
  parameter int SNOOZE_SLOTS = 300
) (
  input logic              clk,
  input logic              rst_n,
  alarm_sequencer_if.slave bus
);
  localparam int SLOT_W = $clog2(TICK_DIV);
  localparam int REP_W  = $clog2(REPEATS + 1);
  localparam int SNZ_W  = $clog2(SNOOZE_SLOTS + 1);
  localparam int HC_W   = PERIOD_W - 1;

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(TICK_DIV - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(LEN - 1);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEATS - 1);
  localparam logic [SNZ_W-1:0]  SNZ_LAST  = SNZ_W'(SNOOZE_SLOTS - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PLAY   = 2'd1,
    ST_SNOOZE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t              state_r, state_s;
  logic                match_q_r;
  logic [ADDR_W-1:0]   addr_r, addr_s, addr_d_s;
  logic [REP_W-1:0]    rep_r, rep_s, rep_d_s;
  logic [SLOT_W-1:0]   slot_r, slot_s, slot_d_s;
  logic [SNZ_W-1:0]    snz_r, snz_s, snz_d_s;
  logic [HC_W-1:0]     hc_r, hc_s, hc_d_s;
  logic                speak_r, speak_s, speak_d_s;
  logic                busy_r, busy_d_s;
  logic                clear_s;
  logic                match_s, trigger_s, slot_wrap_s, rest_s, half_hit_s;
  logic [PERIOD_W-1:0] half_s;

  assign match_s     = (bus.cur_hour == bus.al_hour) && (bus.cur_min == bus.al_min);
  assign trigger_s   = match_s && !match_q_r;
  assign slot_wrap_s = (slot_r == SLOT_LAST);
  assign half_s      = {1'b0, bus.note_period[PERIOD_W-1:1]};
  assign rest_s      = (bus.note_period < PERIOD_W'(2));
  assign half_hit_s  = (({1'b0, hc_r} + PERIOD_W'(1)) == half_s);

  // Next-state and next-counter decode for the playback FSM and tone generator.
  always_comb begin
    state_s = state_r;
    addr_s  = addr_r;
    rep_s   = rep_r;
    slot_s  = slot_r;
    snz_s   = snz_r;
    hc_s    = hc_r;
    speak_s = speak_r;
    clear_s = 1'b0;
    if (!bus.en) begin
      state_s = ST_IDLE;
      clear_s = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          clear_s = 1'b1;
          if (trigger_s) begin
            state_s = ST_PLAY;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_PLAY: begin
          if (bus.stop) begin
            state_s = ST_DONE;
            clear_s = 1'b1;
          end else if (bus.snooze) begin
            state_s = ST_SNOOZE;
            slot_s  = {SLOT_W{1'b0}};
            snz_s   = {SNZ_W{1'b0}};
            hc_s    = {HC_W{1'b0}};
            speak_s = 1'b0;
          end else if (slot_wrap_s) begin
            // Every slot boundary restarts the tone phase for the next note.
            slot_s  = {SLOT_W{1'b0}};
            hc_s    = {HC_W{1'b0}};
            speak_s = 1'b0;
            if (addr_r != ADDR_LAST) begin
              addr_s = addr_r + ADDR_W'(1);
            end else if (rep_r != REP_LAST) begin
              addr_s = {ADDR_W{1'b0}};
              rep_s  = rep_r + REP_W'(1);
            end else begin
              state_s = ST_DONE;
              clear_s = 1'b1;
            end
          end else begin
            slot_s = slot_r + SLOT_W'(1);
            if (rest_s) begin
              hc_s    = {HC_W{1'b0}};
              speak_s = 1'b0;
            end else if (half_hit_s) begin
              hc_s    = {HC_W{1'b0}};
              speak_s = !speak_r;
            end else begin
              hc_s = hc_r + HC_W'(1);
            end
          end
        end
        ST_SNOOZE: begin
          hc_s    = {HC_W{1'b0}};
          speak_s = 1'b0;
          if (bus.stop) begin
            state_s = ST_DONE;
            clear_s = 1'b1;
          end else if (slot_wrap_s) begin
            slot_s = {SLOT_W{1'b0}};
            if (snz_r == SNZ_LAST) begin
              state_s = ST_PLAY;
              addr_s  = {ADDR_W{1'b0}};
              rep_s   = {REP_W{1'b0}};
              snz_s   = {SNZ_W{1'b0}};
            end else begin
              snz_s = snz_r + SNZ_W'(1);
            end
          end else begin
            slot_s = slot_r + SLOT_W'(1);
          end
        end
        ST_DONE: begin
          // Hold here until the matching minute has passed to avoid a retrigger.
          clear_s = 1'b1;
          if (!match_s) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_DONE;
          end
        end
        default: begin
          state_s = ST_IDLE;
          clear_s = 1'b1;
        end
      endcase
    end
  end

  assign addr_d_s  = clear_s ? {ADDR_W{1'b0}} : addr_s;
  assign rep_d_s   = clear_s ? {REP_W{1'b0}}  : rep_s;
  assign slot_d_s  = clear_s ? {SLOT_W{1'b0}} : slot_s;
  assign snz_d_s   = clear_s ? {SNZ_W{1'b0}}  : snz_s;
  assign hc_d_s    = clear_s ? {HC_W{1'b0}}   : hc_s;
  assign speak_d_s = clear_s ? 1'b0           : speak_s;
  assign busy_d_s  = (state_s == ST_PLAY) || (state_s == ST_SNOOZE);

  // State, counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      match_q_r <= 1'b0;
      addr_r    <= {ADDR_W{1'b0}};
      rep_r     <= {REP_W{1'b0}};
      slot_r    <= {SLOT_W{1'b0}};
      snz_r     <= {SNZ_W{1'b0}};
      hc_r      <= {HC_W{1'b0}};
      speak_r   <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      match_q_r <= match_s;
      addr_r    <= addr_d_s;
      rep_r     <= rep_d_s;
      slot_r    <= slot_d_s;
      snz_r     <= snz_d_s;
      hc_r      <= hc_d_s;
      speak_r   <= speak_d_s;
      busy_r    <= busy_d_s;
    end
  end

  assign bus.note_addr = addr_r;
  assign bus.speak     = speak_r;
  assign bus.busy      = busy_r;
endmodule

// File: tb/tb_alarm_sequencer.sv
// Directed bench for alarm_sequencer: LEN=4, TICK_DIV=8, REPEATS=2,
// SNOOZE_SLOTS=3 with the note table {4, 0, 6, 2}.
module tb_alarm_sequencer;
  logic clk;
  logic rst_n;
  int   vectors;
  int   errors;

  alarm_sequencer_if #(.PERIOD_W(20), .ADDR_W(2)) bus ();

  alarm_sequencer #(
    .PERIOD_W(20), .LEN(4), .ADDR_W(2), .TICK_DIV(8), .REPEATS(2), .SNOOZE_SLOTS(3)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  function automatic logic [19:0] rom_f(input logic [1:0] a);
    case (a)
      2'd0:    rom_f = 20'd4;
      2'd1:    rom_f = 20'd0;
      2'd2:    rom_f = 20'd6;
      default: rom_f = 20'd2;
    endcase
  endfunction

  assign bus.note_period = rom_f(bus.note_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Checks n cycles of playback from slot start; expected speak is the
  // square wave that toggles every (P>>1) cycles from the start of each slot.
  task automatic check_play(input int n);
    int a, p, o, sp;
    for (int c = 0; c < n; c++) begin
      a = (c / 8) % 4;
      o = c % 8;
      p = int'(rom_f(2'(a)));
      sp = (p < 2) ? 0 : ((o / (p / 2)) % 2);
      chk($sformatf("addr c%0d", c), 32'(bus.note_addr), 32'(a));
      chk($sformatf("busy c%0d", c), 32'(bus.busy), 32'd1);
      chk($sformatf("speak c%0d", c), 32'(bus.speak), 32'(sp));
      tick(1);
    end
  endtask

  task automatic retrigger();
    bus.cur_min = 6'd31;
    tick(2);
    chk("busy idle before retrigger", 32'(bus.busy), 32'd0);
    bus.cur_min = 6'd30;
    chk("busy before trigger edge", 32'(bus.busy), 32'd0);
    tick(1);
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    rst_n = 1'b0;
    bus.en = 1'b1;
    bus.cur_hour = 6'd7;
    bus.cur_min = 6'd0;
    bus.al_hour = 6'd7;
    bus.al_min = 6'd30;
    bus.snooze = 1'b0;
    bus.stop = 1'b0;
    tick(3);
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset speak", 32'(bus.speak), 32'd0);
    chk("reset addr", 32'(bus.note_addr), 32'd0);
    rst_n = 1'b1;
    tick(2);
    chk("idle busy", 32'(bus.busy), 32'd0);

    // Full uninterrupted playback.
    bus.cur_min = 6'd30;
    chk("busy before first edge", 32'(bus.busy), 32'd0);
    tick(1);
    check_play(64);
    chk("busy after 64", 32'(bus.busy), 32'd0);
    chk("speak after 64", 32'(bus.speak), 32'd0);

    // Match held: no retrigger inside the same minute.
    for (int i = 0; i < 200; i++) begin
      chk($sformatf("no retrigger %0d", i), 32'(bus.busy), 32'd0);
      tick(1);
    end

    // Snooze mid-play, second snooze ignored, then full replay.
    retrigger();
    check_play(20);
    bus.snooze = 1'b1;
    tick(1);
    bus.snooze = 1'b0;
    for (int o = 0; o < 24; o++) begin
      chk($sformatf("snooze busy %0d", o), 32'(bus.busy), 32'd1);
      chk($sformatf("snooze speak %0d", o), 32'(bus.speak), 32'd0);
      bus.snooze = (o == 10);
      tick(1);
    end
    bus.snooze = 1'b0;
    check_play(64);
    chk("busy after replay", 32'(bus.busy), 32'd0);

    // Stop with snooze both high: stop wins.
    retrigger();
    check_play(10);
    bus.stop = 1'b1;
    bus.snooze = 1'b1;
    tick(1);
    bus.stop = 1'b0;
    bus.snooze = 1'b0;
    chk("stop busy", 32'(bus.busy), 32'd0);
    chk("stop speak", 32'(bus.speak), 32'd0);
    tick(3);
    chk("stop stays done", 32'(bus.busy), 32'd0);

    // Stop while snoozing.
    retrigger();
    check_play(5);
    bus.snooze = 1'b1;
    tick(1);
    bus.snooze = 1'b0;
    chk("snooze entry busy", 32'(bus.busy), 32'd1);
    chk("snooze entry speak", 32'(bus.speak), 32'd0);
    tick(3);
    bus.stop = 1'b1;
    tick(1);
    bus.stop = 1'b0;
    chk("stop in snooze busy", 32'(bus.busy), 32'd0);
    chk("stop in snooze speak", 32'(bus.speak), 32'd0);
    tick(5);
    chk("done holds while match", 32'(bus.busy), 32'd0);

    // Enable dropped mid-note.
    retrigger();
    check_play(30);
    bus.en = 1'b0;
    tick(1);
    chk("en low busy", 32'(bus.busy), 32'd0);
    chk("en low speak", 32'(bus.speak), 32'd0);
    chk("en low addr", 32'(bus.note_addr), 32'd0);
    bus.en = 1'b1;
    tick(3);
    chk("en high no trigger", 32'(bus.busy), 32'd0);

    // Asynchronous reset mid-note.
    retrigger();
    check_play(19);
    chk("pre-reset addr", 32'(bus.note_addr), 32'd2);
    chk("pre-reset speak", 32'(bus.speak), 32'd1);
    #2;
    rst_n = 1'b0;
    bus.cur_min = 6'd31;
    #1;
    chk("async reset speak", 32'(bus.speak), 32'd0);
    chk("async reset addr", 32'(bus.note_addr), 32'd0);
    chk("async reset busy", 32'(bus.busy), 32'd0);
    tick(2);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("post-reset idle %0d", i), 32'(bus.busy), 32'd0);
      tick(1);
    end
    bus.cur_min = 6'd30;
    tick(1);
    check_play(64);
    chk("final busy", 32'(bus.busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/alarm_sequencer.md
# alarm_sequencer

Parametrised alarm melody player for the clock design. It compares the running time against a programmable alarm time and, on a match, plays a melody of configurable length from an external note table. Playback supports a configurable repeat count, snooze and stop, and outputs a square-wave `speak` line for the buzzer. It sits between the timekeeping counters and the speaker pin, with the melody ROM living outside the block.

## Interface
Parameters:
- `PERIOD_W`, 20: width of a note period in clock cycles; period 0 means rest.
- `LEN`, 19: number of notes in the melody (≥1).
- `ADDR_W`, 5: width of `note_addr`; must satisfy 2^ADDR_W ≥ LEN.
- `TICK_DIV`, 25_000_000: clock cycles per note slot (≥2).
- `REPEATS`, 3: full melody passes per trigger (≥1).
- `SNOOZE_SLOTS`, 300: silent note slots spent in snooze before replay (≥1).

Ports:
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: asynchronous active-low reset.
- `en`, in, 1: alarm enable; low forces IDLE synchronously.
- `cur_hour`, in, 6: current hour.
- `cur_min`, in, 6: current minute.
- `al_hour`, in, 6: alarm hour.
- `al_min`, in, 6: alarm minute.
- `snooze`, in, 1: level; sampled each cycle.
- `stop`, in, 1: level; sampled each cycle; has priority over `snooze`.
- `note_addr`, out, ADDR_W: melody ROM address.
- `note_period`, in, PERIOD_W: combinational ROM data for `note_addr`.
- `speak`, out, 1: buzzer square wave.
- `busy`, out, 1: high in PLAY or SNOOZE.

## Operation
- `match` = (cur_hour==al_hour) && (cur_min==al_min). `match_q` is `match` delayed by one register. The trigger is `match && !match_q`.
- States and transitions:
  - IDLE: on trigger with `en` high, go to PLAY with note_addr=0, rep=0, slot counter=0.
  - PLAY: the slot counter counts 0..TICK_DIV-1. At wrap:
    - if note_addr<LEN-1, increment note_addr;
    - else if rep<REPEATS-1, set note_addr=0 and rep++;
    - else go to DONE.
  - PLAY, `stop` high: go to DONE. Otherwise `snooze` high: go to SNOOZE with slot counter=0 and snooze count=0.
  - SNOOZE: `speak`=0. Count SNOOZE_SLOTS slots, then go to PLAY with note_addr=0, rep=0. Snooze asserted while already in SNOOZE is ignored; it does not restart the count. `stop` goes to DONE.
  - DONE: `speak`=0. Go to IDLE when `match` is 0. This prevents a retrigger within the same alarm minute.
  - Any state, `en` low: go to IDLE next edge and clear all counters. Reset has the same effect.
- Tone generator: a half-period counter `hc` (PERIOD_W-1 bits) runs in PLAY only.
  - When `hc` == (note_period>>1)-1, `speak` toggles and `hc` clears.
  - If note_period<2, `speak` is held 0 and `hc` is held 0 (rest).
  - On every slot boundary and on entry to PLAY, `hc` and `speak` clear to 0.
- Changing the alarm time during PLAY does not stop playback.

## Timing
- Reset values: state=IDLE, note_addr=0, speak=0, busy=0, match_q=0, all counters 0.
- Trigger latency: `match` rises before edge k. PLAY is active after edge k, and busy=1 from edge k.
- Each note occupies exactly TICK_DIV cycles on `note_addr`.
- Uninterrupted play lasts LEN·TICK_DIV·REPEATS cycles. busy falls on the edge ending the last slot.
- The first `speak` toggle of a note with period P≥2 occurs P/2 cycles after the slot starts. Output frequency is clk/(2·(P>>1)).
- `note_addr` is registered. `note_period` is used in the same cycle it is presented.
- `stop` and `snooze` act on the edge where they are sampled high. `speak` is 0 on that same edge.
- `en` falling mid-note: busy=0 and speak=0 after one edge.
- `rst_n` falling mid-note: outputs clear immediately, without waiting for a clock edge.

## Test plan
Bench parameters: LEN=4, TICK_DIV=8, REPEATS=2, SNOOZE_SLOTS=3, ROM = {4, 0, 6, 2}.

1. Time 07:30 = alarm 07:30, en=1 → busy rises one edge after the match. note_addr sequence is 0,1,2,3,0,1,2,3 with 8 cycles each. busy falls after 64 cycles. During note 0, speak toggles every 2 cycles; during note 1, speak stays 0.
2. Match held for 200 cycles after DONE → no retrigger. Change cur_min and then restore it → a new trigger starts playback.
3. snooze pulse at cycle 20 of play → speak=0 for 24 cycles with busy=1. Replay then restarts at note_addr=0, rep=0, for a full 64 cycles.
4. stop and snooze both high at cycle 10 → DONE, busy=0 and speak=0 next edge. Asserting stop during SNOOZE also goes to DONE.
5. en=0 at cycle 30 → IDLE after one edge. rst_n low mid-note → speak=0 and note_addr=0 asynchronously. After release, the block stays in IDLE until the next trigger.
6. Note with period 2 → speak toggles every cycle. Note with period 0 → speak=0 for the whole slot.
